// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master = operand source + result consumer, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 zero;
    logic                 carry;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, zero, carry
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, zero, carry
    );
endinterface

// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready flow control,
// zero/carry flags and a shift-add multi-cycle multiply.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam logic [2:0] OP_MUL = 3'd7;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [SHW-1:0]       cnt;

    logic                 accept;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   op_res;
    logic                 op_carry;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [SHW-1:0]       sh;

    assign bus.in_ready = (state == IDLE) ||
                          (state == DONE && bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    // partial-product add for the current multiplier bit
    assign step = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        sh       = bus.b[SHW-1:0];
        op_res   = '0;
        op_carry = 1'b0;
        case (bus.sel)
            3'd0: begin
                op_res   = {{(WIDTH-1){1'b0}}, sum};
                op_carry = sum[WIDTH];
            end
            3'd1: begin
                op_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                op_carry = diff[WIDTH];
            end
            3'd2: op_res = {{WIDTH{1'b0}}, bus.a & bus.b};
            3'd3: op_res = {{WIDTH{1'b0}}, bus.a | bus.b};
            3'd4: op_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            3'd5: op_res = {{WIDTH{1'b0}}, (bus.a << sh)};
            3'd6: op_res = {{WIDTH{1'b0}}, (bus.a >> sh)};
            default: begin
                op_res   = '0;
                op_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept && bus.sel == OP_MUL) begin
                        state         <= MUL;
                        bus.out_valid <= 1'b0;
                        acc           <= '0;
                        mcand         <= {{WIDTH{1'b0}}, bus.a};
                        mplier        <= bus.b;
                        cnt           <= SHW'(WIDTH - 1);
                    end else if (accept) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= op_res;
                        bus.zero      <= (op_res == '0);
                        bus.carry     <= op_carry;
                    end else if (state == DONE && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    // last step: publish the completed product
                    if (cnt == '0) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= step;
                        bus.zero      <= (step == '0);
                        bus.carry     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases
// plus randomized back-to-back traffic against a reference model.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [2*W-1:0] r;
        logic           z;
        logic           c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int unsigned a,
                                   input int unsigned b,
                                   input int unsigned s);
        exp_t        e;
        int unsigned r;
        int unsigned c;
        r = 0;
        c = 0;
        case (s)
            0: begin r = a + b; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b) & 255; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << (b % W)) & 255;
            6: r = a >> (b % W);
            default: r = a * b;
        endcase
        e.r = 16'(r);
        e.z = (r == 0);
        e.c = c[0];
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [2:0] s);
        int n;
        n = 0;
        bus.a = a;
        bus.b = b;
        bus.sel = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b need 1",
                     bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.sel = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.zero, bus.carry} !== 3'b000 ||
            bus.result !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: v=%b z=%b c=%b r=%h need 0",
                     bus.out_valid, bus.zero, bus.carry, bus.result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b need 1/0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_ops();
        logic [7:0]  ta [6] = '{8'd200, 8'd5, 8'd9, 8'h81, 8'h80, 8'hC3};
        logic [7:0]  tb [6] = '{8'd100, 8'd7, 8'd9, 8'd9, 8'd7, 8'h00};
        logic [2:0]  ts [6] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd6};
        logic [15:0] tr [6] = '{16'h012C, 16'h00FE, 16'h0000,
                                16'h0002, 16'h0001, 16'h00C3};
        logic [1:0]  tf [6] = '{2'b01, 2'b01, 2'b10,
                                2'b00, 2'b00, 2'b00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(ta[i], tb[i], ts[i]);
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result !== tr[i] ||
                {bus.zero, bus.carry} !== tf[i]) begin
                fails++;
                $display("FAIL op%0d: v=%b r=%h zc=%b%b need 1 %h %b",
                         i, bus.out_valid, bus.result,
                         bus.zero, bus.carry, tr[i], tf[i]);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL op%0d_idle: out_valid=%b need 0",
                         i, bus.out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mul();
        logic [7:0]  ma [2] = '{8'd255, 8'd0};
        logic [15:0] mr [2] = '{16'hFE01, 16'h0000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(ma[i], ma[i], 3'd7);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                tests++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL mul%0d_busy c%0d: rdy=%b v=%b need 0/0",
                             i, c, bus.in_ready, bus.out_valid);
                end
            end
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result !== mr[i] ||
                bus.zero !== (i == 1) || bus.carry !== 1'b0) begin
                fails++;
                $display("FAIL mul%0d_done: v=%b r=%h z=%b c=%b need 1 %h",
                         i, bus.out_valid, bus.result,
                         bus.zero, bus.carry, mr[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(8'hF0, 8'h0F, 3'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result !== 16'h00FF ||
                bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold c%0d: v=%b r=%h rdy=%b need 1 00ff 0",
                         c, bus.out_valid, bus.result, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h0F;
        bus.sel = 3'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready: in_ready=%b need 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.result !== 16'h00F0) begin
            fails++;
            $display("FAIL bp_next: v=%b r=%h need 1 00f0",
                     bus.out_valid, bus.result);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_idle: out_valid=%b need 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        seen = 1'b0;
        bus.out_ready = 1'b1;
        send(8'd3, 8'd4, 3'd7);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.out_valid, bus.zero, bus.carry} !== 3'b000 ||
            bus.result !== 16'h0) begin
            fails++;
            $display("FAIL rst_mul_async: v=%b z=%b c=%b r=%h need 0",
                     bus.out_valid, bus.zero, bus.carry, bus.result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mul_ready: in_ready=%b need 1",
                     bus.in_ready);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.result === 16'd12)
                seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL rst_mul_ghost: result seen=%b need 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        bit   hold;
        int   n;
        hold = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
                bus.sel = 3'($urandom_range(0, 7));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra: r=%h need no result",
                             bus.result);
                end else if ({bus.result, bus.zero, bus.carry} !== q[0])
                begin
                    fails++;
                    $display("FAIL b2b_data: r=%h z=%b c=%b need %h %b %b",
                             bus.result, bus.zero, bus.carry,
                             q[0].r, q[0].z, q[0].c);
                end
                if (bus.out_ready && q.size() != 0) void'(q.pop_front());
            end
            hold = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.sel));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                e = q.pop_front();
                tests++;
                if ({bus.result, bus.zero, bus.carry} !== e) begin
                    fails++;
                    $display("FAIL b2b_drain: r=%h z=%b c=%b need %h %b %b",
                             bus.result, bus.zero, bus.carry,
                             e.r, e.z, e.c);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL b2b_timeout: %0d results outstanding need 0",
                     q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
